// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared UART constants and receiver state encoding.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;
   localparam int DEFAULT_CLK_FREQ = 48_000_000;
   localparam int DEFAULT_BAUD     = 115_200;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_t;
endpackage

`default_nettype wire

// File: rtl/sync_ff2.sv
// ---------------------------------------------------------------------------
// sync_ff2 : two-flop synchroniser for an asynchronous input.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_ff2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 8N1 receiver with valid/ready byte output, framing/overrun flags. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
   parameter int BAUD     = DEFAULT_BAUD
) (
   input  logic       clk_48mhz,
   input  logic       reset_n,
   input  logic       rx_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

   logic             rx_s;
   rx_state_t        state, state_n;
   logic [CNT_W-1:0] clk_cnt, cnt_n;
   logic [2:0]       bit_idx, idx_n;
   logic [7:0]       shift, shift_n;
   logic             byte_done, done_n;
   logic             ferr_n;

   sync_ff2 #(.RESET_VAL(1'b1)) u_sync (
      .clk     (clk_48mhz),
      .reset_n (reset_n),
      .d       (rx_in),
      .q       (rx_s)
   );

   always_ff @(posedge clk_48mhz) begin
      if (!reset_n) begin
         state     <= IDLE;
         clk_cnt   <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         byte_done <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         clk_cnt   <= cnt_n;
         bit_idx   <= idx_n;
         shift     <= shift_n;
         byte_done <= done_n;
         frame_err <= ferr_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = clk_cnt + 1'b1;
      idx_n   = bit_idx;
      shift_n = shift;
      done_n  = 1'b0;
      ferr_n  = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (!rx_s) state_n = START;
         end
         START: begin
            // Mid-start check rejects low glitches shorter than half a bit
            if (clk_cnt == HALF_END) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (clk_cnt == BIT_END) begin
               cnt_n   = '0;
               shift_n = {rx_s, shift[7:1]};
               idx_n   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_n = STOP;
            end
         end
         STOP: begin
            if (clk_cnt == BIT_END) begin
               cnt_n   = '0;
               state_n = rx_s ? IDLE : BREAK;
               done_n  = rx_s;
               ferr_n  = !rx_s;
            end
         end
         BREAK: begin
            cnt_n = '0;
            if (rx_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // A same-cycle handshake frees the holding register for the new byte
   always_ff @(posedge clk_48mhz) begin
      if (!reset_n) begin
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (byte_done) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= shift;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);
endmodule

`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver that sits directly upstream of the SoC's byte-level serial logic.
- Takes the raw asynchronous serial pin (PMOD_B3 path), synchronises it, times each bit from the system clock, and presents whole bytes on a valid/ready handshake.
- Also flags framing errors and overruns.
- The top level instantiates it between the PMOD pin and the SoC's receive byte interface.

Parameters:
- CLK_FREQ, 48000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division; 416 at defaults), clocks per bit; localparam.
- HALF_BIT, CLKS_PER_BIT/2 (208), clocks from start-bit edge to mid-start sample; localparam.

Ports:
- clk_48mhz  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- rx_in  input  1  raw asynchronous serial line; idles high.
- rx_data  output  8  received byte; stable while rx_valid=1.
- rx_valid  output  1  holding register contains an unread byte.
- rx_ready  input  1  consumer accepts the byte when rx_valid&rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a completed byte was dropped because the holding register was full.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - synchroniser flops=1, FSM=IDLE, bit counter=0, clock counter=0, shift register=0.
  - rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Reset mid-frame aborts the frame; no byte and no error are produced.
- Synchroniser: two flops. rx_s is the second flop. All FSM decisions use rx_s only, giving 2 cycles of pin-to-FSM latency.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - If rx_s==0, go to START and clear the clock counter.
- START:
  - Count to HALF_BIT-1, then sample rx_s.
  - Sample 1: glitch; return to IDLE, no outputs.
  - Sample 0: go to DATA; clear the clock counter and bit index.
- DATA:
  - Every CLKS_PER_BIT clocks (counter reaches CLKS_PER_BIT-1), sample rx_s into the shift register, LSB first.
  - After the sample with bit index 7, go to STOP.
- STOP:
  - After CLKS_PER_BIT clocks, sample rx_s.
  - Sample 1: byte complete; go to IDLE.
  - Sample 0: pulse frame_err for 1 cycle, discard the byte, go to BREAK.
- BREAK:
  - Wait for rx_s==1, then go to IDLE. This prevents a held-low line from re-triggering.
- Byte completion, evaluated on the cycle after the stop sample:
  - rx_valid=0: load rx_data, set rx_valid=1.
  - rx_valid=1 and rx_ready=1 in the same cycle: the old byte is consumed, the new byte is loaded, rx_valid stays 1.
  - rx_valid=1 and rx_ready=0: the new byte is dropped, rx_data is unchanged, and overrun pulses for 1 cycle.
- rx_valid clears on the cycle after rx_valid&rx_ready, unless a load occurs in that same cycle.
- Latency: rx_valid rises ~9.5 bit times after the start-bit falling edge: 2 sync cycles + HALF_BIT + 9×CLKS_PER_BIT + 1 cycle.
- The stop bit is sampled mid-bit, so the next start bit may begin half a bit after the stop sample. IDLE accepts it immediately, with no extra idle time required.
- Counters:
  - The clock counter is $clog2(CLKS_PER_BIT) bits wide and never wraps within a state; it is cleared on every state change and every sample.
  - The bit index is 3 bits wide.

Decomposition:
- Package uart_pkg holds:
  - the rx_state_t enum (IDLE, START, DATA, STOP, BREAK);
  - the default CLK_FREQ and BAUD constants, shared with the future uart_tx.
- Sub-module sync_ff2: 2-flop synchroniser with parameterised reset value (1 here), reusable for other PMOD inputs.

Test Plan:
- Send 0x55 at 416 clk/bit, rx_ready=1 -> rx_valid pulses for exactly 1 cycle with rx_data=0x55 at ~3954 cycles after the start edge (±2); frame_err=0, overrun=0.
- Send 0xA3 with rx_ready=0, then raise rx_ready 100 cycles later -> rx_valid held with rx_data=0xA3 until the handshake; clears the next cycle.
- Low glitch of 100 cycles on an idle line -> no rx_valid and no frame_err; busy high for ≤HALF_BIT+3 cycles, then 0.
- Frame 0x3C with stop bit driven 0, line held low 2000 cycles, then high -> frame_err single pulse; no rx_valid; FSM sits in BREAK until the line goes high, then the next frame 0x7E is received correctly.
- Two back-to-back frames 0x11, 0x22 with rx_ready=0 -> rx_data stays 0x11, overrun pulses once at the second completion; with rx_ready=1 asserted at the second completion cycle instead -> rx_data=0x22, rx_valid stays 1, no overrun.
- Assert reset_n=0 for 1 cycle mid-DATA of frame 0xF0 -> all outputs 0 next cycle, the partial frame is dropped; the following clean frame 0x0F is received as 0x0F.
